// File: rtl/baser_257b_transcoder_if.sv
// Handshake bundle for the 64B/66B -> 256B/257B transcoder: 66b input side, 257b output side, counters.
// BASER_257B_ERR_INJECT_EN adds the i_inject_err strobe.
interface baser_257b_transcoder_if #(
    parameter int FRAME_WIDTH = 66,
    parameter int TC_WIDTH    = 257
);
    logic                   i_valid;
    logic [FRAME_WIDTH-1:0] i_tx_coded;
    logic                   o_ready;
    logic                   o_valid;
    logic [TC_WIDTH-1:0]    o_tx_xcoded;
    logic                   i_ready;
    logic [31:0]            o_block_count;
    logic [31:0]            o_err_count;
`ifdef BASER_257B_ERR_INJECT_EN
    logic                   i_inject_err;
`endif

    modport slave (
`ifdef BASER_257B_ERR_INJECT_EN
        input  i_inject_err,
`endif
        input  i_valid, i_tx_coded, i_ready,
        output o_ready, o_valid, o_tx_xcoded, o_block_count, o_err_count
    );

    modport master (
`ifdef BASER_257B_ERR_INJECT_EN
        output i_inject_err,
`endif
        output i_valid, i_tx_coded, i_ready,
        input  o_ready, o_valid, o_tx_xcoded, o_block_count, o_err_count
    );
endinterface

// File: rtl/baser_257b_transcoder.sv
// Transmit 64B/66B -> 256B/257B transcoder: gathers four 66b blocks into one 257b block, flags illegal groups.
// Optional error injection port under BASER_257B_ERR_INJECT_EN.
module baser_257b_transcoder #(
    parameter int DATA_WIDTH  = 64,
    parameter int HDR_WIDTH   = 2,
    parameter int FRAME_WIDTH = DATA_WIDTH + HDR_WIDTH,
    parameter int TC_WIDTH    = 4*DATA_WIDTH + 1
) (
    input logic                    clk,
    input logic                    i_rst,
    baser_257b_transcoder_if.slave bus
);

    localparam logic [HDR_WIDTH-1:0] HDR_DATA = 2'b10;
    localparam logic [HDR_WIDTH-1:0] HDR_CTRL = 2'b01;

    function automatic logic legal_type(input logic [7:0] t);
        case (t)
            8'h1E, 8'h78, 8'h4B, 8'h87, 8'h99, 8'hAA,
            8'hB4, 8'hCC, 8'hD2, 8'hE1, 8'hFF: legal_type = 1'b1;
            default:                           legal_type = 1'b0;
        endcase
    endfunction

    // First control block loses type[7:4]; remaining payload packs above type[3:0].
    function automatic logic [DATA_WIDTH-5:0] squeeze(input logic [DATA_WIDTH-1:0] p);
        squeeze = {p[DATA_WIDTH-1:8], p[3:0]};
    endfunction

    logic [1:0]             slot_q, slot_d;
    logic [FRAME_WIDTH-1:0] buf_q [3];
    logic [FRAME_WIDTH-1:0] buf_d [3];
    logic                   valid_q, valid_d;
    logic [TC_WIDTH-1:0]    xcoded_q, xcoded_d;
    logic                   err_q, err_d;
    logic [31:0]            blk_cnt_q, blk_cnt_d;
    logic [31:0]            err_cnt_q, err_cnt_d;

    logic ready, accept, load, drain, inject;

    assign ready  = (slot_q != 2'd3) || !valid_q || bus.i_ready;
    assign accept = bus.i_valid && ready;
    assign load   = accept && (slot_q == 2'd3);
    assign drain  = valid_q && bus.i_ready;

`ifdef BASER_257B_ERR_INJECT_EN
    assign inject = bus.i_inject_err;
`else
    assign inject = 1'b0;
`endif

    logic [3:0][FRAME_WIDTH-1:0] grp;
    logic [3:0][DATA_WIDTH-1:0]  pay;
    logic [3:0]                  is_data, is_ctrl, is_bad;
    logic [1:0]                  first_idx;
    logic [DATA_WIDTH-1:0]       first_pay;
    logic                        all_data, any_bad, type_ok, enc_err;
    logic [TC_WIDTH-1:0]         data_word, ctrl_word, bad_word, enc_word;

    // The slot-3 block is taken straight from the input so the group encodes in its handshake cycle.
    assign grp = {bus.i_tx_coded, buf_q[2], buf_q[1], buf_q[0]};

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            pay[k]     = grp[k][FRAME_WIDTH-1:HDR_WIDTH];
            is_data[k] = (grp[k][HDR_WIDTH-1:0] == HDR_DATA);
            is_ctrl[k] = (grp[k][HDR_WIDTH-1:0] == HDR_CTRL);
            is_bad[k]  = !is_data[k] && !is_ctrl[k];
        end
    end

    always_comb begin
        first_idx = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (is_ctrl[k]) first_idx = 2'(k);
        end
    end

    assign first_pay = pay[first_idx];
    assign all_data  = &is_data;
    assign any_bad   = |is_bad;
    assign type_ok   = legal_type(first_pay[7:0]);
    assign enc_err   = inject || any_bad || (!all_data && !type_ok);

    assign data_word = {pay[3], pay[2], pay[1], pay[0], 1'b1};
    assign bad_word  = {pay[3], pay[2], pay[1], squeeze(pay[0]), 4'b1111, 1'b0};

    always_comb begin
        ctrl_word = '0;
        case (first_idx)
            2'd0: ctrl_word = {pay[3], pay[2], pay[1], squeeze(pay[0]), is_data, 1'b0};
            2'd1: ctrl_word = {pay[3], pay[2], squeeze(pay[1]), pay[0], is_data, 1'b0};
            2'd2: ctrl_word = {pay[3], squeeze(pay[2]), pay[1], pay[0], is_data, 1'b0};
            default: ctrl_word = {squeeze(pay[3]), pay[2], pay[1], pay[0], is_data, 1'b0};
        endcase
    end

    assign enc_word = enc_err ? bad_word : (all_data ? data_word : ctrl_word);

    always_comb begin
        slot_d    = slot_q;
        buf_d     = buf_q;
        valid_d   = valid_q;
        xcoded_d  = xcoded_q;
        err_d     = err_q;
        blk_cnt_d = blk_cnt_q;
        err_cnt_d = err_cnt_q;
        if (accept) begin
            slot_d = slot_q + 2'd1;
            for (int k = 0; k < 3; k++) begin
                if (slot_q == 2'(k)) buf_d[k] = bus.i_tx_coded;
            end
        end
        if (drain) begin
            valid_d   = 1'b0;
            blk_cnt_d = blk_cnt_q + 32'd1;
            if (err_q) err_cnt_d = err_cnt_q + 32'd1;
        end
        // Load after drain so a same-cycle drain and reload leaves no bubble.
        if (load) begin
            valid_d  = 1'b1;
            xcoded_d = enc_word;
            err_d    = enc_err;
        end
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            slot_q    <= '0;
            buf_q     <= '{default: '0};
            valid_q   <= 1'b0;
            xcoded_q  <= '0;
            err_q     <= 1'b0;
            blk_cnt_q <= '0;
            err_cnt_q <= '0;
        end else begin
            slot_q    <= slot_d;
            buf_q     <= buf_d;
            valid_q   <= valid_d;
            xcoded_q  <= xcoded_d;
            err_q     <= err_d;
            blk_cnt_q <= blk_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign bus.o_ready       = ready;
    assign bus.o_valid       = valid_q;
    assign bus.o_tx_xcoded   = xcoded_q;
    assign bus.o_block_count = blk_cnt_q;
    assign bus.o_err_count   = err_cnt_q;

endmodule

// File: tb/tb_baser_257b_transcoder.sv
// Bench for baser_257b_transcoder: directed cases plus random groups against a bit-stream reference model.
module tb_baser_257b_transcoder;

    logic clk = 1'b0;
    logic i_rst;
    always #5 clk = ~clk;

    baser_257b_transcoder_if bus ();

    baser_257b_transcoder dut (
        .clk  (clk),
        .i_rst(i_rst),
        .bus  (bus)
    );

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] legal_list [11] = '{8'h1E, 8'h78, 8'h4B, 8'h87, 8'h99, 8'hAA,
                                    8'hB4, 8'hCC, 8'hD2, 8'hE1, 8'hFF};

    logic [256:0] exp_q [$];
    bit           exp_err_q [$];
    int unsigned  m_blk, m_err;
    bit           mon_en;
    bit           hold_pending;
    logic [256:0] hold_data;

    logic [3:0][65:0] tb_grp;
    int               tb_idx;

    logic [256:0] mr;
    int           mp;

    task automatic chk(input string tag, input logic [256:0] obs, input logic [256:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic void put(input logic [63:0] v, input int n);
        for (int i = 0; i < n; i++) mr[mp+i] = v[i];
        mp += n;
    endfunction

    // Reference: emit the 257b block LSB-first as a bit stream from the transcoding rules.
    function automatic logic [256:0] model(input logic [3:0][65:0] g, input bit inj, output bit err);
        bit bad = 0, alld = 1;
        int f = -1;
        for (int k = 0; k < 4; k++) begin
            if (g[k][1:0] == 2'b00 || g[k][1:0] == 2'b11) bad = 1;
            if (g[k][1:0] != 2'b10) alld = 0;
            if (g[k][1:0] == 2'b01 && f < 0) f = k;
        end
        err = inj || bad || (!alld && f >= 0 && !(g[f][9:2] inside {8'h1E, 8'h78, 8'h4B, 8'h87,
              8'h99, 8'hAA, 8'hB4, 8'hCC, 8'hD2, 8'hE1, 8'hFF}));
        mr = '0;
        mp = 0;
        if (err) begin
            put(64'd0, 1); put(64'hF, 4); put(64'(g[0][5:2]), 4); put(64'(g[0][65:10]), 56);
            for (int k = 1; k < 4; k++) put(g[k][65:2], 64);
        end else if (alld) begin
            put(64'd1, 1);
            for (int k = 0; k < 4; k++) put(g[k][65:2], 64);
        end else begin
            put(64'd0, 1);
            for (int k = 0; k < 4; k++) put(64'(g[k][1:0] == 2'b10), 1);
            for (int k = 0; k < 4; k++) begin
                if (k == f) begin
                    put(64'(g[k][5:2]), 4);
                    put(64'(g[k][65:10]), 56);
                end else begin
                    put(g[k][65:2], 64);
                end
            end
        end
        return mr;
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            if (hold_pending) begin
                chk("hold_valid", 257'(bus.o_valid), 257'(1));
                chk("hold_data", bus.o_tx_xcoded, hold_data);
            end
            hold_pending = bus.o_valid && !bus.i_ready;
            hold_data    = bus.o_tx_xcoded;
            if (bus.o_valid && bus.i_ready) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_output", 257'(bus.o_valid), 257'(0));
                end else begin
                    chk("xcoded", bus.o_tx_xcoded, exp_q.pop_front());
                    m_blk++;
                    if (exp_err_q.pop_front()) m_err++;
                end
            end
        end
    end

    task automatic send(input logic [65:0] blk, input bit inj = 0);
        bit got = 0;
        bit e;
        bit inj_eff;
        logic [256:0] w;
        bus.i_valid    = 1'b1;
        bus.i_tx_coded = blk;
`ifdef BASER_257B_ERR_INJECT_EN
        bus.i_inject_err = inj;
        inj_eff = inj;
`else
        inj_eff = 1'b0;
`endif
        for (int n = 0; n < 500 && !got; n++) begin
            @(negedge clk);
            if (bus.o_ready) got = 1;
        end
        if (!got) chk("send_timeout", 257'(bus.o_ready), 257'(1));
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
`ifdef BASER_257B_ERR_INJECT_EN
        bus.i_inject_err = 1'b0;
`endif
        tb_grp[tb_idx] = blk;
        tb_idx++;
        if (tb_idx == 4) begin
            w = model(tb_grp, inj_eff, e);
            exp_q.push_back(w);
            exp_err_q.push_back(e);
            tb_idx = 0;
        end
    endtask

    task automatic do_reset();
        mon_en = 0;
        i_rst = 1'b1;
        bus.i_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 257'(bus.o_valid), 257'(0));
        chk("rst_xcoded", bus.o_tx_xcoded, 257'(0));
        chk("rst_blk_cnt", 257'(bus.o_block_count), 257'(0));
        chk("rst_err_cnt", 257'(bus.o_err_count), 257'(0));
        @(posedge clk);
        #1;
        i_rst = 1'b0;
        exp_q.delete();
        exp_err_q.delete();
        tb_idx = 0;
        m_blk = 0;
        m_err = 0;
        hold_pending = 0;
        mon_en = 1;
    endtask

    task automatic drain_check(input string tag);
        bus.i_ready = 1'b1;
        for (int n = 0; n < 50 && exp_q.size() != 0; n++) @(posedge clk);
        repeat (2) @(posedge clk);
        #1;
        chk({tag, "_pending"}, 257'(exp_q.size()), 257'(0));
        chk({tag, "_blk_cnt"}, 257'(bus.o_block_count), 257'(m_blk));
        chk({tag, "_err_cnt"}, 257'(bus.o_err_count), 257'(m_err));
    endtask

    function automatic logic [65:0] data_blk(input logic [63:0] p);
        return {p, 2'b10};
    endfunction

    function automatic logic [65:0] ctrl_blk(input logic [7:0] t, input logic [55:0] rest);
        return {rest, t, 2'b01};
    endfunction

    function automatic logic [65:0] rand_blk();
        int r = $urandom_range(0, 99);
        logic [63:0] p = {$urandom, $urandom};
        if (r < 65) return {p, 2'b10};
        if (r < 94) begin
            if ($urandom_range(0, 4) != 0) p[7:0] = legal_list[$urandom_range(0, 10)];
            return {p, 2'b01};
        end
        return {p, ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b00};
    endfunction

    logic [65:0]  blk_a;
    logic [256:0] word_a;
    bit           rnd_done;

    initial begin
        bus.i_valid    = 1'b0;
        bus.i_tx_coded = '0;
        bus.i_ready    = 1'b1;
`ifdef BASER_257B_ERR_INJECT_EN
        bus.i_inject_err = 1'b0;
`endif
        i_rst = 1'b1;
        repeat (2) @(posedge clk);
        do_reset();

        // All-data group, checked against literal values.
        for (int k = 0; k < 4; k++) send(data_blk(64'hAAAA_AAAA_AAAA_AAAA));
        chk("aa_valid", 257'(bus.o_valid), 257'(1));
        chk("aa_word", bus.o_tx_xcoded, {{32{8'hAA}}, 1'b1});
        @(posedge clk);
        #1;
        chk("aa_blk_cnt", 257'(bus.o_block_count), 257'(1));
        chk("aa_err_cnt", 257'(bus.o_err_count), 257'(0));

        // Control in slot 1 with legal type.
        send(data_blk(64'h1111_1111_1111_1111));
        send(ctrl_blk(8'h1E, 56'h1E1E_1E1E_1E1E_1E));
        send(data_blk(64'h2222_2222_2222_2222));
        send(data_blk(64'h3333_3333_3333_3333));
        chk("ctrl_hdr", 257'(bus.o_tx_xcoded[4:0]), 257'(5'b11010));
        drain_check("ctrl1");

        // Illegal sync header in block 0.
        send({64'h0123_4567_89AB_CDEF, 2'b11});
        for (int k = 0; k < 3; k++) send(data_blk({$urandom, $urandom}));
        chk("badhdr_low", 257'(bus.o_tx_xcoded[4:0]), 257'(5'b11110));
        drain_check("badhdr");
        chk("badhdr_err_cnt", 257'(bus.o_err_count), 257'(1));

        // Illegal first control type, then an illegal type after a legal first control.
        send(data_blk({$urandom, $urandom}));
        send(ctrl_blk(8'h55, 56'hABCDEF_0123_4567));
        send(data_blk({$urandom, $urandom}));
        send(data_blk({$urandom, $urandom}));
        drain_check("type55_first");
        chk("type55_err_cnt", 257'(bus.o_err_count), 257'(2));
        send(ctrl_blk(8'h1E, 56'h11_2233_4455_6677));
        send(data_blk({$urandom, $urandom}));
        send(ctrl_blk(8'h55, 56'h99_8877_6655_4433));
        send(ctrl_blk(8'h00, 56'h00_0000_0000_0001));
        drain_check("type55_later");
        chk("type55_later_err", 257'(bus.o_err_count), 257'(2));

`ifdef BASER_257B_ERR_INJECT_EN
        send(data_blk(64'h5));
        send(data_blk(64'h6));
        send(data_blk(64'h7));
        send(data_blk(64'h8), 1'b1);
        drain_check("inject");
`endif

        // Backpressure: full output register stalls only the 4th block; release gives drain+load.
        bus.i_ready = 1'b0;
        for (int k = 0; k < 4; k++) send(data_blk({$urandom, $urandom}));
        word_a = exp_q[0];
        for (int k = 0; k < 3; k++) send(data_blk({$urandom, $urandom}));
        blk_a = data_blk(64'hFEED_FACE_CAFE_BEEF);
        fork
            send(blk_a);
            begin
                repeat (3) @(negedge clk);
                #1;
                chk("stall_ready", 257'(bus.o_ready), 257'(0));
                chk("stall_word", bus.o_tx_xcoded, word_a);
                @(posedge clk);
                #1;
                bus.i_ready = 1'b1;
            end
        join
        chk("reload_valid", 257'(bus.o_valid), 257'(1));
        chk("reload_word", bus.o_tx_xcoded, exp_q[exp_q.size()-1]);
        drain_check("stall");

        // Reset mid-gather drops the partial group.
        send(data_blk(64'hDEAD_DEAD_DEAD_DEAD));
        send(data_blk(64'hDEAD_DEAD_DEAD_DEAD));
        do_reset();
        for (int k = 0; k < 4; k++) send(data_blk(64'h0101_0101_0101_0101 * (k + 1)));
        chk("post_rst_word", bus.o_tx_xcoded,
            {64'h0404_0404_0404_0404, 64'h0303_0303_0303_0303,
             64'h0202_0202_0202_0202, 64'h0101_0101_0101_0101, 1'b1});
        drain_check("post_rst");
        chk("post_rst_blk_cnt", 257'(bus.o_block_count), 257'(1));

        // Random groups with random downstream backpressure.
        rnd_done = 0;
        fork
            begin
                for (int g = 0; g < 150; g++)
                    for (int k = 0; k < 4; k++) send(rand_blk());
                rnd_done = 1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1;
                    bus.i_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        drain_check("random");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
